// File: rtl/regfile_mp.sv
// regfile_mp: parametrised integer register file with NRD combinational read ports,
// optional same-cycle write-to-read bypass, per-register busy scoreboard and a
// post-reset clear sequencer that zeroes the storage array one entry per cycle.
module regfile_mp #(
   parameter int unsigned XLEN     = 32,
   parameter int unsigned NREGS    = 32,
   parameter int unsigned AW       = 5,
   parameter int unsigned NRD      = 2,
   parameter int unsigned ZERO_REG = 1,
   parameter int unsigned BYPASS   = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   output logic                ready,
   input  logic                we,
   input  logic [AW-1:0]       waddr,
   input  logic [XLEN-1:0]     wdata,
   input  logic                busy_set,
   input  logic [AW-1:0]       busy_addr,
   input  logic [NRD*AW-1:0]   raddr,
   output logic [NRD*XLEN-1:0] rdata,
   output logic [NRD-1:0]      rbusy
);

   typedef enum logic [0:0] {StClear, StRun} state_e;

   // One bit wider than an address so the terminal compare cannot wrap.
   localparam logic [AW:0] LastIdx = (AW+1)'(NREGS - 1);
   localparam logic [AW:0] OneIdx  = (AW+1)'(1);

   state_e            state_q;
   logic [AW:0]       clr_idx_q;
   logic              ready_q;
   logic [NREGS-1:0]  busy_q;
   logic [NREGS-1:0]  busy_d;
   logic [XLEN-1:0]   mem [NREGS];

   logic              run;
   logic              wr_ok;
   logic              mem_we;
   logic [AW-1:0]     mem_waddr;
   logic [XLEN-1:0]   mem_wdata;

   assign run   = (state_q == StRun);
   assign ready = ready_q;

   // A write is architecturally visible only in RUN and never to a hardwired x0.
   always_comb begin
      wr_ok = run && we;
      if (ZERO_REG != 0 && waddr == '0) begin
         wr_ok = 1'b0;
      end
   end

   // Storage write port is shared between the clear sequencer and the writeback port.
   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = waddr;
      mem_wdata = wdata;
      if (rst_n) begin
         if (state_q == StClear) begin
            mem_we    = 1'b1;
            mem_waddr = clr_idx_q[AW-1:0];
            mem_wdata = '0;
         end else begin
            mem_we = wr_ok;
         end
      end
   end

   // Storage array: no reset, cleared by the sequencer instead.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_waddr] <= mem_wdata;
      end
   end

   // Scoreboard next state: retire first, then issue so a same-address set wins.
   always_comb begin
      busy_d = busy_q;
      if (we) begin
         busy_d[waddr] = 1'b0;
      end
      if (busy_set) begin
         busy_d[busy_addr] = 1'b1;
      end
      if (ZERO_REG != 0) begin
         busy_d[0] = 1'b0;
      end
   end

   // Control FSM: clear sequencer, ready flag and busy scoreboard.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= StClear;
         clr_idx_q <= '0;
         ready_q   <= 1'b0;
         busy_q    <= '0;
      end else begin
         unique case (state_q)
            StClear: begin
               clr_idx_q <= clr_idx_q + OneIdx;
               if (clr_idx_q == LastIdx) begin
                  state_q <= StRun;
                  ready_q <= 1'b1;
               end
            end
            StRun: begin
               busy_q <= busy_d;
            end
            default: begin
               state_q <= StClear;
            end
         endcase
      end
   end

   for (genvar i = 0; i < NRD; i++) begin : g_rd
      logic [AW-1:0]   ra;
      logic [XLEN-1:0] rd;
      logic            rb;
      logic            fwd;

      assign ra  = raddr[i*AW +: AW];
      assign fwd = (BYPASS != 0) && wr_ok && (waddr == ra);

      // Read port: x0 forces zero, bypass forwards wdata and hides the busy bit.
      always_comb begin
         rd = mem[ra];
         rb = busy_q[ra];
         if (!run) begin
            rd = '0;
            rb = 1'b0;
         end else if (ZERO_REG != 0 && ra == '0) begin
            rd = '0;
            rb = 1'b0;
         end else if (fwd) begin
            rd = wdata;
            rb = 1'b0;
         end
      end

      assign rdata[i*XLEN +: XLEN] = rd;
      assign rbusy[i]              = rb;
   end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: scoreboard bench for regfile_mp. Three instances: default build (a),
// BYPASS=0 build sharing a's stimulus (b), and a 64-bit/16-entry/3-port build (c).
module tb_regfile_mp;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        we;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic        busy_set;
   logic [4:0]  busy_addr;
   logic [9:0]  raddr;
   logic        a_ready, b_ready;
   logic [63:0] a_rdata, b_rdata;
   logic [1:0]  a_rbusy, b_rbusy;

   logic         c_we;
   logic [3:0]   c_waddr;
   logic [63:0]  c_wdata;
   logic         c_busy_set;
   logic [3:0]   c_busy_addr;
   logic [11:0]  c_raddr;
   logic         c_ready;
   logic [191:0] c_rdata;
   logic [2:0]   c_rbusy;

   regfile_mp u_a (
      .clk(clk), .rst_n(rst_n), .ready(a_ready), .we(we), .waddr(waddr), .wdata(wdata),
      .busy_set(busy_set), .busy_addr(busy_addr), .raddr(raddr), .rdata(a_rdata),
      .rbusy(a_rbusy)
   );

   regfile_mp #(.BYPASS(0)) u_b (
      .clk(clk), .rst_n(rst_n), .ready(b_ready), .we(we), .waddr(waddr), .wdata(wdata),
      .busy_set(busy_set), .busy_addr(busy_addr), .raddr(raddr), .rdata(b_rdata),
      .rbusy(b_rbusy)
   );

   regfile_mp #(.XLEN(64), .NREGS(16), .AW(4), .NRD(3), .ZERO_REG(0)) u_c (
      .clk(clk), .rst_n(rst_n), .ready(c_ready), .we(c_we), .waddr(c_waddr),
      .wdata(c_wdata), .busy_set(c_busy_set), .busy_addr(c_busy_addr), .raddr(c_raddr),
      .rdata(c_rdata), .rbusy(c_rbusy)
   );

   typedef struct {
      string       tag;
      int          sel;
      logic [63:0] exp;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] obs(input int sel);
      case (sel)
         0:  return {63'd0, a_ready};
         1:  return {32'd0, a_rdata[31:0]};
         2:  return {32'd0, a_rdata[63:32]};
         3:  return {63'd0, a_rbusy[0]};
         4:  return {63'd0, a_rbusy[1]};
         5:  return {32'd0, b_rdata[63:32]};
         6:  return {63'd0, b_ready};
         7:  return {63'd0, b_rbusy[0]};
         8:  return {63'd0, c_ready};
         9:  return c_rdata[63:0];
         10: return c_rdata[127:64];
         11: return c_rdata[191:128];
         default: return '1;
      endcase
   endfunction

   task automatic push(input string tag, input int sel, input logic [63:0] exp);
      exp_t e;
      e.tag = tag;
      e.sel = sel;
      e.exp = exp;
      sb.push_back(e);
   endtask

   // Inputs are driven at the falling edge; outputs sampled 2 time units later.
   task automatic settle();
      exp_t e;
      #2;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         check_eq(e.tag, obs(e.sel), e.exp);
      end
      @(negedge clk);
   endtask

   task automatic rd(input logic [4:0] p0, input logic [4:0] p1);
      raddr = {p1, p0};
   endtask

   // e counts rising edges since rst_n was released; ready must stay low for 32 of them.
   task automatic clear_run(input bit with_c, input bit inject);
      for (int e = 0; e < 32; e++) begin
         if (inject && e == 20) begin
            we = 1'b1; waddr = 5'd6; wdata = 32'h0000_0abc;
            busy_set = 1'b1; busy_addr = 5'd8;
         end else begin
            we = 1'b0; busy_set = 1'b0;
         end
         push("clr_ready_a", 0, 64'd0);
         push("clr_ready_b", 6, 64'd0);
         push("clr_rdata0", 1, 64'd0);
         push("clr_rdata1", 2, 64'd0);
         push("clr_rbusy0", 3, 64'd0);
         if (with_c) push("clr_ready_c", 8, (e >= 16) ? 64'd1 : 64'd0);
         settle();
      end
      we = 1'b0; busy_set = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; we = 1'b0; waddr = '0; wdata = '0; busy_set = 1'b0; busy_addr = '0;
      rd(5'd7, 5'd0);
      c_we = 1'b0; c_waddr = '0; c_wdata = '0; c_busy_set = 1'b0; c_busy_addr = '0;
      c_raddr = '0;
      repeat (3) @(negedge clk);
      push("rst_ready", 0, 64'd0);
      push("rst_rdata0", 1, 64'd0);
      push("rst_rbusy0", 3, 64'd0);
      #2;
      while (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         check_eq(e.tag, obs(e.sel), e.exp);
      end
      @(negedge clk);
      rst_n = 1'b1;
      clear_run(1'b1, 1'b0);

      // Edge 32 has passed: ready up, cleared register reads zero.
      push("ready_a", 0, 64'd1);
      push("ready_b", 6, 64'd1);
      push("ready_c", 8, 64'd1);
      push("x7_zero", 1, 64'd0);
      settle();

      // Basic write, plus the wide build writing its ordinary register 0.
      we = 1'b1; waddr = 5'd5; wdata = 32'hdead_beef; rd(5'd0, 5'd0);
      c_we = 1'b1; c_waddr = 4'd0; c_wdata = 64'hffff_0000_aaaa_5555;
      push("x0_rd_during_wr", 1, 64'd0);
      settle();
      we = 1'b0; rd(5'd5, 5'd5);
      c_we = 1'b0; c_raddr = '0;
      push("rd5_p0", 1, 64'hdead_beef);
      push("rd5_p1", 2, 64'hdead_beef);
      push("rd5_b_p1", 5, 64'hdead_beef);
      push("c_r0_p0", 9, 64'hffff_0000_aaaa_5555);
      push("c_r0_p1", 10, 64'hffff_0000_aaaa_5555);
      push("c_r0_p2", 11, 64'hffff_0000_aaaa_5555);
      settle();

      // x0 write is discarded and not forwarded.
      we = 1'b1; waddr = 5'd0; wdata = 32'h0000_1234; rd(5'd0, 5'd0);
      push("x0_bypass_p0", 1, 64'd0);
      push("x0_bypass_b", 5, 64'd0);
      settle();
      we = 1'b0;
      push("x0_after", 2, 64'd0);
      settle();

      // Bypass: a forwards, b returns the old value.
      we = 1'b1; waddr = 5'd9; wdata = 32'h11;
      settle();
      we = 1'b1; waddr = 5'd9; wdata = 32'h22; rd(5'd9, 5'd9);
      push("byp_a_p0", 1, 64'h22);
      push("byp_a_p1", 2, 64'h22);
      push("byp_b_p1", 5, 64'h11);
      settle();
      we = 1'b0;
      push("post_byp_a", 2, 64'h22);
      push("post_byp_b", 5, 64'h22);
      settle();

      // Scoreboard.
      busy_set = 1'b1; busy_addr = 5'd12; rd(5'd12, 5'd0);
      push("busy_not_yet", 3, 64'd0);
      settle();
      busy_set = 1'b0;
      push("busy_set_a", 3, 64'd1);
      push("busy_set_b", 7, 64'd1);
      settle();
      busy_set = 1'b1; busy_addr = 5'd12; we = 1'b1; waddr = 5'd12; wdata = 32'h77;
      push("busy_fwd_a", 3, 64'd0);
      push("busy_fwd_b", 7, 64'd1);
      push("busy_fwd_data", 1, 64'h77);
      settle();
      busy_set = 1'b0; we = 1'b0;
      push("set_wins_a", 3, 64'd1);
      push("set_wins_b", 7, 64'd1);
      settle();
      we = 1'b1; waddr = 5'd12; wdata = 32'h78;
      push("retire_a", 3, 64'd0);
      push("retire_b", 7, 64'd1);
      settle();
      we = 1'b0;
      push("retired_a", 3, 64'd0);
      push("retired_b", 7, 64'd0);
      settle();
      busy_set = 1'b1; busy_addr = 5'd0; rd(5'd0, 5'd0);
      settle();
      busy_set = 1'b0;
      push("busy_x0", 3, 64'd0);
      settle();
      busy_set = 1'b1; busy_addr = 5'd3; we = 1'b1; waddr = 5'd4; wdata = 32'h44;
      settle();
      busy_set = 1'b0; we = 1'b0; rd(5'd3, 5'd4);
      push("diff_set", 3, 64'd1);
      push("diff_clr", 4, 64'd0);
      push("diff_data", 2, 64'h44);
      settle();

      // Reset part-way through clear, with a write and busy_set injected during clear.
      rd(5'd3, 5'd5);
      rst_n = 1'b0;
      settle();
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      clear_run(1'b0, 1'b1);
      push("re_ready_a", 0, 64'd1);
      push("re_busy3", 3, 64'd0);
      push("re_x5_zero", 2, 64'd0);
      settle();
      rd(5'd8, 5'd6);
      push("clr_busy_ignored", 3, 64'd0);
      push("clr_we_ignored_a", 2, 64'd0);
      push("clr_we_ignored_b", 5, 64'd0);
      settle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
